food_sprite_engine: RTL and testbench
=====================================

// Module: food_sprite_engine
// PURPOSE
//  Pipelined, animated generator for one food sprite: a small dot or a pulsing, blinking power pellet.
//  Sits between the tile renderer and the pixel mux.
//  Takes a sprite-relative (x,y) each cycle; returns the colour 2 cycles later with a valid flag.
//  Holds per-sprite state: present/eaten, pellet pulse radius, blink phase.
// PARAMETERS
//  SPRITE_W     80          sprite width/height in pixels; centre = SPRITE_W/2
//  REL_BITS     7           width of x/y; 2**REL_BITS >= SPRITE_W
//  COLOR_BITS   8           pixel colour width
//  FOOD_COLOR   8'hFF       colour inside the disc
//  BG_COLOR     8'h00       colour outside the disc / when hidden
//  DOT_R        15          dot radius (mode=0)
//  PWR_R_MIN    18          pellet min radius (mode=1)
//  PWR_R_MAX    26          pellet max radius, PWR_R_MIN < PWR_R_MAX <= SPRITE_W/2
//  PULSE_DIV    4           frame_ticks per 1-pixel radius step
//  BLINK_FRAMES 15          frame_ticks per blink half-period
// PORTS
//  clk         in   1           pixel clock
//  rst         in   1           synchronous, active-high reset
//  frame_tick  in   1           1-cycle pulse per video frame
//  mode        in   1           0 = dot, 1 = power pellet
//  eaten       in   1           1-cycle pulse: Pac-Man consumed this food
//  respawn     in   1           1-cycle pulse: restore food (new level)
//  in_valid    in   1           x/y valid this cycle
//  x           in   REL_BITS    sprite-relative column
//  y           in   REL_BITS    sprite-relative row
//  out_valid   out  1           pixels valid
//  pixels      out  COLOR_BITS  colour for the (x,y) issued 2 cycles earlier
//  present     out  1           1 while food not eaten
// BEHAVIOUR
//  Reset: out_valid=0, pixels=BG_COLOR, present=1, radius=PWR_R_MAX, dir=SHRINK,
//   blink_on=1, all counters=0, state=PRESENT.
//  Pipeline: fixed latency 2, no stall. Throughput is 1 pixel/cycle.
//   S1 registers dx=x-C and dy=y-C (signed, REL_BITS+1) and an oob flag (x>=SPRITE_W or y>=SPRITE_W).
//   S2 registers pixels = (!oob && visible && dx*dx+dy*dy < r*r) ? FOOD_COLOR : BG_COLOR.
//   Squares are 2*(REL_BITS+1) bits; the sum is 1 bit wider. Compare is strict (<).
//   out_valid = in_valid delayed 2 cycles. Pixels register even when in_valid=0, but only
//   out_valid-qualified values are meaningful.
//  r = DOT_R if mode=0, else the current pulse radius. visible = present && (mode==0 || blink_on).
//   Both are sampled at S1, so an in-flight pixel uses the state from its S1 cycle.
//  FSM PRESENT/EATEN:
//   PRESENT --eaten--> EATEN; EATEN --respawn--> PRESENT. present=(state==PRESENT).
//   eaten and respawn in the same cycle: respawn wins (state=PRESENT).
//   eaten while EATEN, or respawn while PRESENT: no effect.
//  Pulse (mode=1, PRESENT, on frame_tick):
//   pulse_cnt increments; at PULSE_DIV-1 it wraps to 0 and radius steps 1 in dir.
//   At PWR_R_MIN dir becomes GROW; at PWR_R_MAX dir becomes SHRINK. Radius never leaves the range.
//  Blink (mode=1, PRESENT, on frame_tick): blink_cnt wraps at BLINK_FRAMES-1; on wrap blink_on toggles.
//  mode=0 or EATEN: pulse and blink counters hold.
//  Any respawn or mode 0->1 edge: radius=PWR_R_MAX, dir=SHRINK, blink_on=1, counters=0.
//  Mid-operation rst: flushes both stages (out_valid=0 next cycle) and restores all reset values.
// STRUCTURE
//  Shared package/include: REL_BITS, COLOR_BITS, SPRITE_W, colour constants, FSM state encodings.
//  Sub-module food_anim_ctrl: the FSM plus pulse/blink counters, outputs radius/visible/present.
//  The top level holds the 2-stage disc pipeline.
// TESTING
//  1) rst, then in_valid=1, x=y=40, mode=0 -> 2 cycles later out_valid=1, pixels=8'hFF.
//     x=40,y=55 (d^2=225) -> 8'h00.
//  2) mode=0, sweep x,y over 0..79 -> exactly the points with d^2<225 are 8'hFF; x=90 -> 8'h00.
//  3) mode=1, 4*8=32 frame_ticks -> radius 26->18. Next 4 ticks -> 19.
//     (40,40+18) black at r=18, white at r=19.
//  4) mode=1, 15 frame_ticks -> blink_on=0, all pixels 8'h00. 15 more -> visible again.
//  5) eaten pulse -> present=0, all pixels 8'h00. eaten+respawn same cycle -> present=1.
//     respawn -> radius=26.
//  6) assert rst with out_valid=1 mid-stream -> out_valid=0 next cycle, pixels=8'h00, present=1.

Source files
------------

// File: rtl/food_sprite_pkg.sv
// Shared constants for the food sprite engine: geometry, colours, animation timing,
// and the legacy FSM / pulse-direction encodings.
package food_sprite_pkg;

  localparam int SPRITE_W     = 80;
  localparam int REL_BITS     = 7;
  localparam int COLOR_BITS   = 8;
  localparam int DOT_R        = 15;
  localparam int PWR_R_MIN    = 18;
  localparam int PWR_R_MAX    = 26;
  localparam int PULSE_DIV    = 4;
  localparam int BLINK_FRAMES = 15;

  localparam logic [COLOR_BITS-1:0] FOOD_COLOR = 8'hFF;
  localparam logic [COLOR_BITS-1:0] BG_COLOR   = 8'h00;

  localparam logic ST_PRESENT = 1'b0;
  localparam logic ST_EATEN   = 1'b1;

  localparam logic DIR_SHRINK = 1'b0;
  localparam logic DIR_GROW   = 1'b1;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/food_anim_ctrl.sv
// Present/eaten FSM plus the power-pellet pulse radius and blink phase; presents the
// radius and visibility the disc pipeline should use this cycle.
module food_anim_ctrl
  import food_sprite_pkg::*;
#(
  parameter int REL_BITS     = food_sprite_pkg::REL_BITS,
  parameter int DOT_R        = food_sprite_pkg::DOT_R,
  parameter int PWR_R_MIN    = food_sprite_pkg::PWR_R_MIN,
  parameter int PWR_R_MAX    = food_sprite_pkg::PWR_R_MAX,
  parameter int PULSE_DIV    = food_sprite_pkg::PULSE_DIV,
  parameter int BLINK_FRAMES = food_sprite_pkg::BLINK_FRAMES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic                mode,
  input  logic                eaten,
  input  logic                respawn,
  output logic [REL_BITS-1:0] radius,
  output logic                visible,
  output logic                present
);

  localparam int PC_W = cnt_width(PULSE_DIV);
  localparam int BC_W = cnt_width(BLINK_FRAMES);

  localparam logic [REL_BITS-1:0] R_MIN = REL_BITS'(PWR_R_MIN);
  localparam logic [REL_BITS-1:0] R_MAX = REL_BITS'(PWR_R_MAX);
  localparam logic [REL_BITS-1:0] R_DOT = REL_BITS'(DOT_R);
  localparam logic [REL_BITS-1:0] R_ONE = REL_BITS'(1);
  localparam logic [PC_W-1:0]     PC_LAST = PC_W'(PULSE_DIV - 1);
  localparam logic [BC_W-1:0]     BC_LAST = BC_W'(BLINK_FRAMES - 1);

  logic                state_q, state_d;
  logic                mode_q;
  logic [REL_BITS-1:0] radius_q, radius_d;
  logic                dir_q, dir_d;
  logic                blink_on_q, blink_on_d;
  logic [PC_W-1:0]     pulse_cnt_q, pulse_cnt_d;
  logic [BC_W-1:0]     blink_cnt_q, blink_cnt_d;

  always_comb begin
    state_d     = state_q;
    radius_d    = radius_q;
    dir_d       = dir_q;
    blink_on_d  = blink_on_q;
    pulse_cnt_d = pulse_cnt_q;
    blink_cnt_d = blink_cnt_q;

    if (respawn)    state_d = ST_PRESENT;
    else if (eaten) state_d = ST_EATEN;

    // A respawn or entering pellet mode restarts the animation from its initial phase.
    if (respawn || (mode && !mode_q)) begin
      radius_d    = R_MAX;
      dir_d       = DIR_SHRINK;
      blink_on_d  = 1'b1;
      pulse_cnt_d = '0;
      blink_cnt_d = '0;
    end else if (mode && (state_q == ST_PRESENT) && frame_tick) begin
      if (pulse_cnt_q == PC_LAST) begin
        pulse_cnt_d = '0;
        if ((dir_q == DIR_SHRINK) && (radius_q > R_MIN))   radius_d = radius_q - R_ONE;
        else if ((dir_q == DIR_GROW) && (radius_q < R_MAX)) radius_d = radius_q + R_ONE;
        if (radius_d == R_MIN)      dir_d = DIR_GROW;
        else if (radius_d == R_MAX) dir_d = DIR_SHRINK;
      end else begin
        pulse_cnt_d = pulse_cnt_q + PC_W'(1);
      end

      if (blink_cnt_q == BC_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = !blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PRESENT;
      mode_q      <= 1'b0;
      radius_q    <= R_MAX;
      dir_q       <= DIR_SHRINK;
      blink_on_q  <= 1'b1;
      pulse_cnt_q <= '0;
      blink_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode;
      radius_q    <= radius_d;
      dir_q       <= dir_d;
      blink_on_q  <= blink_on_d;
      pulse_cnt_q <= pulse_cnt_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign present = (state_q == ST_PRESENT);
  assign visible = present && (!mode || blink_on_q);
  assign radius  = mode ? radius_q : R_DOT;

endmodule

// File: rtl/food_sprite_engine.sv
// Two-stage disc pipeline for one food sprite: S1 centres the coordinate and latches the
// animation state, S2 does the squared-distance test and registers the colour.
module food_sprite_engine
  import food_sprite_pkg::*;
#(
  parameter int                               SPRITE_W     = food_sprite_pkg::SPRITE_W,
  parameter int                               REL_BITS     = food_sprite_pkg::REL_BITS,
  parameter int                               COLOR_BITS   = food_sprite_pkg::COLOR_BITS,
  parameter logic [COLOR_BITS-1:0]            FOOD_COLOR   = food_sprite_pkg::FOOD_COLOR,
  parameter logic [COLOR_BITS-1:0]            BG_COLOR     = food_sprite_pkg::BG_COLOR,
  parameter int                               DOT_R        = food_sprite_pkg::DOT_R,
  parameter int                               PWR_R_MIN    = food_sprite_pkg::PWR_R_MIN,
  parameter int                               PWR_R_MAX    = food_sprite_pkg::PWR_R_MAX,
  parameter int                               PULSE_DIV    = food_sprite_pkg::PULSE_DIV,
  parameter int                               BLINK_FRAMES = food_sprite_pkg::BLINK_FRAMES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_tick,
  input  logic                  mode,
  input  logic                  eaten,
  input  logic                  respawn,
  input  logic                  in_valid,
  input  logic [REL_BITS-1:0]   x,
  input  logic [REL_BITS-1:0]   y,
  output logic                  out_valid,
  output logic [COLOR_BITS-1:0] pixels,
  output logic                  present
);

  localparam int W     = REL_BITS + 1;
  localparam int SQ_W  = 2 * W;
  localparam int SUM_W = SQ_W + 1;

  localparam logic signed [W-1:0] CTR  = W'(SPRITE_W / 2);
  localparam logic        [W-1:0] WLIM = W'(SPRITE_W);

  logic [REL_BITS-1:0] radius;
  logic                visible;

  food_anim_ctrl #(
    .REL_BITS     (REL_BITS),
    .DOT_R        (DOT_R),
    .PWR_R_MIN    (PWR_R_MIN),
    .PWR_R_MAX    (PWR_R_MAX),
    .PULSE_DIV    (PULSE_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_anim (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .mode       (mode),
    .eaten      (eaten),
    .respawn    (respawn),
    .radius     (radius),
    .visible    (visible),
    .present    (present)
  );

  logic                   v1_q, v2_q;
  logic                   oob_q, vis_q;
  logic signed [W-1:0]    dx_q, dy_q, dx_d, dy_d;
  logic [REL_BITS-1:0]    r_q;
  logic [COLOR_BITS-1:0]  pix_q, pix_d;

  logic signed [SQ_W-1:0] dx_sq, dy_sq;
  logic [SUM_W-1:0]       d2, r_ext, rr;

  assign dx_d = $signed({1'b0, x}) - CTR;
  assign dy_d = $signed({1'b0, y}) - CTR;

  assign dx_sq = dx_q * dx_q;
  assign dy_sq = dy_q * dy_q;
  assign d2    = {1'b0, dx_sq} + {1'b0, dy_sq};
  assign r_ext = {{(SUM_W-REL_BITS){1'b0}}, r_q};
  assign rr    = r_ext * r_ext;
  assign pix_d = (!oob_q && vis_q && (d2 < rr)) ? FOOD_COLOR : BG_COLOR;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      oob_q <= 1'b0;
      vis_q <= 1'b0;
      dx_q  <= '0;
      dy_q  <= '0;
      r_q   <= '0;
      v2_q  <= 1'b0;
      pix_q <= BG_COLOR;
    end else begin
      v1_q  <= in_valid;
      oob_q <= ({1'b0, x} >= WLIM) || ({1'b0, y} >= WLIM);
      vis_q <= visible;
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      r_q   <= radius;
      v2_q  <= v1_q;
      pix_q <= pix_d;
    end
  end

  assign out_valid = v2_q;
  assign pixels    = pix_q;

endmodule

// File: tb/tb_food_sprite_engine.sv
// Directed bench for food_sprite_engine: dot disc, pellet pulse/blink, eat/respawn, reset.
module tb_food_sprite_engine;

  logic       clk = 1'b0;
  logic       rst, frame_tick, mode, eaten, respawn, in_valid;
  logic [6:0] x, y;
  logic       out_valid, present;
  logic [7:0] pixels;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  food_sprite_engine dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .mode       (mode),
    .eaten      (eaten),
    .respawn    (respawn),
    .in_valid   (in_valid),
    .x          (x),
    .y          (y),
    .out_valid  (out_valid),
    .pixels     (pixels),
    .present    (present)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; tick();
      frame_tick = 1'b0; tick();
    end
  endtask

  task automatic probe(input int px, input int py, output logic [7:0] p, output logic v);
    x = px[6:0]; y = py[6:0]; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    p = pixels; v = out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++;
    if (pixels !== 8'h00) $display("FAIL reset_pixels: got %h want 00", pixels); else pass_cnt++;
    chk_cnt++;
    if (present !== 1'b1) $display("FAIL reset_present: got %b want 1", present); else pass_cnt++;
  endtask

  task automatic test_dot_basic();
    mode = 1'b0;
    x = 7'd40; y = 7'd40; in_valid = 1'b1;
    tick();
    x = 7'd40; y = 7'd55;
    tick();
    chk_cnt++;
    if (out_valid !== 1'b1 || pixels !== 8'hFF)
      $display("FAIL dot_center: valid=%b pixels=%h want 1/ff", out_valid, pixels); else pass_cnt++;
    in_valid = 1'b0;
    tick();
    chk_cnt++;
    if (out_valid !== 1'b1 || pixels !== 8'h00)
      $display("FAIL dot_edge225: valid=%b pixels=%h want 1/00", out_valid, pixels); else pass_cnt++;
    tick();
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL dot_valid_drop: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_dot_sweep();
    int px, py, dx, dy, errs;
    logic [7:0] exp_p, p;
    logic v;
    errs = 0;
    mode = 1'b0;
    for (int i = 0; i <= 6400; i++) begin
      if (i < 6400) begin
        x = 7'(i % 80); y = 7'(i / 80); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        px = (i - 1) % 80; py = (i - 1) / 80;
        dx = px - 40; dy = py - 40;
        exp_p = (dx * dx + dy * dy < 225) ? 8'hFF : 8'h00;
        chk_cnt++;
        if (out_valid !== 1'b1 || pixels !== exp_p) begin
          if (errs < 10)
            $display("FAIL sweep(%0d,%0d): valid=%b pixels=%h want 1/%h", px, py, out_valid, pixels, exp_p);
          errs++;
        end else pass_cnt++;
      end
    end
    probe(90, 40, p, v);
    chk_cnt++;
    if (v !== 1'b1 || p !== 8'h00) $display("FAIL oob_x90: valid=%b pixels=%h want 1/00", v, p); else pass_cnt++;
    probe(40, 80, p, v);
    chk_cnt++;
    if (v !== 1'b1 || p !== 8'h00) $display("FAIL oob_y80: valid=%b pixels=%h want 1/00", v, p); else pass_cnt++;
  endtask

  task automatic test_pulse();
    logic [7:0] p;
    logic v;
    mode = 1'b1; tick();
    probe(40, 65, p, v);
    chk_cnt++;
    if (p !== 8'hFF) $display("FAIL r26_in625: got %h want ff", p); else pass_cnt++;
    probe(40, 66, p, v);
    chk_cnt++;
    if (p !== 8'h00) $display("FAIL r26_out676: got %h want 00", p); else pass_cnt++;
    frames(32);
    probe(40, 58, p, v);
    chk_cnt++;
    if (p !== 8'h00) $display("FAIL r18_out324: got %h want 00", p); else pass_cnt++;
    probe(40, 57, p, v);
    chk_cnt++;
    if (p !== 8'hFF) $display("FAIL r18_in289: got %h want ff", p); else pass_cnt++;
    frames(4);
    probe(40, 58, p, v);
    chk_cnt++;
    if (p !== 8'hFF) $display("FAIL r19_in324: got %h want ff", p); else pass_cnt++;
  endtask

  task automatic test_blink();
    logic [7:0] p;
    logic v;
    mode = 1'b0; tick();
    mode = 1'b1; tick();
    frames(14);
    probe(40, 40, p, v);
    chk_cnt++;
    if (p !== 8'hFF) $display("FAIL blink_14_on: got %h want ff", p); else pass_cnt++;
    frames(1);
    probe(40, 40, p, v);
    chk_cnt++;
    if (p !== 8'h00) $display("FAIL blink_15_off: got %h want 00", p); else pass_cnt++;
    probe(45, 45, p, v);
    chk_cnt++;
    if (p !== 8'h00) $display("FAIL blink_off_45: got %h want 00", p); else pass_cnt++;
    frames(15);
    probe(40, 40, p, v);
    chk_cnt++;
    if (p !== 8'hFF) $display("FAIL blink_30_on: got %h want ff", p); else pass_cnt++;
    frames(15);
    mode = 1'b0;
    probe(40, 40, p, v);
    chk_cnt++;
    if (p !== 8'hFF) $display("FAIL blink_dot_ignores: got %h want ff", p); else pass_cnt++;
    mode = 1'b1; tick();
    probe(40, 40, p, v);
    chk_cnt++;
    if (p !== 8'hFF) $display("FAIL blink_mode_restart: got %h want ff", p); else pass_cnt++;
  endtask

  task automatic test_eaten();
    logic [7:0] p;
    logic v;
    eaten = 1'b1; tick(); eaten = 1'b0;
    chk_cnt++;
    if (present !== 1'b0) $display("FAIL eaten_present: got %b want 0", present); else pass_cnt++;
    probe(40, 40, p, v);
    chk_cnt++;
    if (p !== 8'h00) $display("FAIL eaten_pellet_hidden: got %h want 00", p); else pass_cnt++;
    mode = 1'b0;
    probe(40, 40, p, v);
    chk_cnt++;
    if (p !== 8'h00) $display("FAIL eaten_dot_hidden: got %h want 00", p); else pass_cnt++;
    mode = 1'b1; tick();
    eaten = 1'b1; respawn = 1'b1; tick(); eaten = 1'b0; respawn = 1'b0;
    chk_cnt++;
    if (present !== 1'b1) $display("FAIL both_from_eaten: got %b want 1", present); else pass_cnt++;
    probe(40, 40, p, v);
    chk_cnt++;
    if (p !== 8'hFF) $display("FAIL respawn_visible: got %h want ff", p); else pass_cnt++;
    eaten = 1'b1; respawn = 1'b1; tick(); eaten = 1'b0; respawn = 1'b0;
    chk_cnt++;
    if (present !== 1'b1) $display("FAIL both_from_present: got %b want 1", present); else pass_cnt++;
    frames(8);
    probe(40, 65, p, v);
    chk_cnt++;
    if (p !== 8'h00) $display("FAIL r24_out625: got %h want 00", p); else pass_cnt++;
    respawn = 1'b1; tick(); respawn = 1'b0;
    probe(40, 65, p, v);
    chk_cnt++;
    if (p !== 8'hFF) $display("FAIL respawn_r26: got %h want ff", p); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    eaten = 1'b1; tick(); eaten = 1'b0;
    x = 7'd40; y = 7'd40; in_valid = 1'b1;
    tick(); tick();
    chk_cnt++;
    if (out_valid !== 1'b1) $display("FAIL mid_stream_valid: got %b want 1", out_valid); else pass_cnt++;
    rst = 1'b1; tick();
    rst = 1'b0; in_valid = 1'b0;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++;
    if (pixels !== 8'h00) $display("FAIL rst_mid_pixels: got %h want 00", pixels); else pass_cnt++;
    chk_cnt++;
    if (present !== 1'b1) $display("FAIL rst_mid_present: got %b want 1", present); else pass_cnt++;
    tick();
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL rst_s1_flush: got %b want 0", out_valid); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; mode = 1'b0; eaten = 1'b0; respawn = 1'b0;
    in_valid = 1'b0; x = '0; y = '0;
    test_reset();
    test_dot_basic();
    test_dot_sweep();
    test_pulse();
    test_blink();
    test_eaten();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
